// File: rtl/sixteen_register_file.sv
// 8 x 16-bit register file: two combinational read ports, one synchronous write port, R0 reads zero.
// Optional RF_WRITE_BYPASS_EN: write-first forwarding of in_write_data onto matching read ports.
module sixteen_register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int REG_COUNT  = 8
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_write_enable,
  input  logic [ADDR_WIDTH-1:0] in_write_address,
  input  logic [DATA_WIDTH-1:0] in_write_data,
  input  logic [ADDR_WIDTH-1:0] in_read_address_one,
  input  logic [ADDR_WIDTH-1:0] in_read_address_two,
  output logic [DATA_WIDTH-1:0] ou_read_one,
  output logic [DATA_WIDTH-1:0] ou_read_two
);

  logic [DATA_WIDTH-1:0] w_regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] w_stored_one;
  logic [DATA_WIDTH-1:0] w_stored_two;

  // R0 is a constant, not storage, so it can never hold a written value.
  assign w_regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] r_data;

      always_ff @(posedge in_clk) begin
        if (in_reset) begin
          r_data <= '0;
        end else if (in_write_enable && (in_write_address == ADDR_WIDTH'(gi))) begin
          r_data <= in_write_data;
        end
      end

      assign w_regs[gi] = r_data;
    end
  endgenerate

  assign w_stored_one = w_regs[in_read_address_one];
  assign w_stored_two = w_regs[in_read_address_two];

`ifdef RF_WRITE_BYPASS_EN
  logic w_write_live;
  logic w_bypass_one;
  logic w_bypass_two;

  // Forwarding only when the write would actually land at this edge.
  assign w_write_live = in_write_enable && !in_reset && (in_write_address != '0);
  assign w_bypass_one = w_write_live && (in_read_address_one == in_write_address);
  assign w_bypass_two = w_write_live && (in_read_address_two == in_write_address);

  assign ou_read_one = w_bypass_one ? in_write_data : w_stored_one;
  assign ou_read_two = w_bypass_two ? in_write_data : w_stored_two;
`else
  assign ou_read_one = w_stored_one;
  assign ou_read_two = w_stored_two;
`endif

endmodule

// File: tb/tb_sixteen_register_file.sv
// Scoreboard bench for sixteen_register_file: stimulus queues expected read values per cycle,
// a negedge monitor pops and compares them against both read ports.
module tb_sixteen_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  wa;
  logic [15:0] wd;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic [15:0] rd1;
  logic [15:0] rd2;

  typedef struct {
    string       name;
    logic [15:0] e1;
    logic [15:0] e2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic bypass_on;

  sixteen_register_file #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .REG_COUNT (8)
  ) dut (
    .in_clk              (clk),
    .in_reset            (rst),
    .in_write_enable     (we),
    .in_write_address    (wa),
    .in_write_data       (wd),
    .in_read_address_one (ra1),
    .in_read_address_two (ra2),
    .ou_read_one         (rd1),
    .ou_read_two         (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t it;
      it = exp_q.pop_front();
      total++;
      if (rd1 !== it.e1) begin
        bad++;
        $display("FAIL %s port1: got %h want %h", it.name, rd1, it.e1);
      end
      total++;
      if (rd2 !== it.e2) begin
        bad++;
        $display("FAIL %s port2: got %h want %h", it.name, rd2, it.e2);
      end
      $display("check %s: ra1=%0d rd1=%h ra2=%0d rd2=%h", it.name, ra1, rd1, ra2, rd2);
    end
  end

  // One clock cycle of stimulus; optionally queue the expected read values for this cycle.
  task automatic cyc(input logic r, input logic w, input logic [2:0] a, input logic [15:0] d,
                     input logic [2:0] a1, input logic [2:0] a2,
                     input logic chk, input logic [15:0] e1, input logic [15:0] e2,
                     input string name);
    exp_t it;
    @(posedge clk);
    #1;
    rst = r; we = w; wa = a; wd = d; ra1 = a1; ra2 = a2;
    if (chk) begin
      it.name = name; it.e1 = e1; it.e2 = e2;
      exp_q.push_back(it);
    end
  endtask

  initial begin
`ifdef RF_WRITE_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    rst = 1'b1; we = 1'b0; wa = 3'd0; wd = 16'h0; ra1 = 3'd0; ra2 = 3'd0;

    // Reset held two cycles; the second one already follows a reset edge.
    cyc(1, 1, 3'd3, 16'h5555, 3'd3, 3'd3, 0, 16'h0, 16'h0, "rst0");
    cyc(1, 1, 3'd3, 16'h5555, 3'd3, 3'd6, 1, 16'h0, 16'h0, "rst_hold");
    for (int a = 0; a < 8; a++) begin
      cyc(0, 0, 3'd0, 16'h0, 3'(a), 3'(7 - a), 1, 16'h0, 16'h0, "rst_sweep");
    end

    // Basic write/read
    cyc(0, 1, 3'd3, 16'hA5A5, 3'd0, 3'd0, 0, 16'h0, 16'h0, "wr_r3");
    cyc(0, 1, 3'd7, 16'h1234, 3'd3, 3'd7, 1, 16'hA5A5, bypass_on ? 16'h1234 : 16'h0000, "wr_r7_rd");
    cyc(0, 0, 3'd0, 16'h0, 3'd3, 3'd7, 1, 16'hA5A5, 16'h1234, "rd_r3_r7");
    cyc(0, 0, 3'd0, 16'h0, 3'd5, 3'd5, 1, 16'h0, 16'h0, "rd_r5_both");

    // R0 hardwired
    cyc(0, 1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1, 16'h0, 16'h0, "wr_r0");
    cyc(0, 0, 3'd0, 16'h0, 3'd0, 3'd0, 1, 16'h0, 16'h0, "r0_after");
    cyc(0, 0, 3'd0, 16'h0, 3'd0, 3'd7, 1, 16'h0, 16'h1234, "r0_later");

    // Write-enable gating
    cyc(0, 1, 3'd2, 16'h00FF, 3'd0, 3'd0, 0, 16'h0, 16'h0, "wr_r2");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 3'd2, 16'hDEAD, 3'd2, 3'd2, 1, 16'h00FF, 16'h00FF, "we_gate");
    end
    cyc(0, 0, 3'd0, 16'h0, 3'd2, 3'd3, 1, 16'h00FF, 16'hA5A5, "we_gate_after");

    // Same-cycle read/write
    cyc(0, 1, 3'd4, 16'hBEEF, 3'd2, 3'd4, 1, 16'h00FF, bypass_on ? 16'hBEEF : 16'h0000, "rw_same");
    cyc(0, 0, 3'd0, 16'h0, 3'd4, 3'd4, 1, 16'hBEEF, 16'hBEEF, "rw_after");

    // Reset mid-operation with a competing write
    cyc(0, 1, 3'd1, 16'h1111, 3'd4, 3'd7, 1, 16'hBEEF, 16'h1234, "wr_r1");
    cyc(1, 1, 3'd1, 16'h2222, 3'd1, 3'd7, 1, 16'h1111, 16'h1234, "rst_mid");
    cyc(0, 0, 3'd0, 16'h0, 3'd1, 3'd3, 1, 16'h0, 16'h0, "rst_mid_r1_r3");
    cyc(0, 1, 3'd1, 16'h3333, 3'd1, 3'd7, 1, bypass_on ? 16'h3333 : 16'h0000, 16'h0, "wr_after_rst");
    cyc(0, 0, 3'd0, 16'h0, 3'd1, 3'd4, 1, 16'h3333, 16'h0, "rd_after_rst");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
